// File: rtl/fp_special_pipe.sv
//-----------------------------------------------------------------------------
// fp_special_pipe
//   Two-stage special-case resolver for a floating-point adder/subtractor.
//   Classifies both operands, resolves NaN / zero / infinity cases to a
//   final result and flags inf-inf.
//   Revision: 1.0
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fp_special_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4,
   parameter int FTZ   = 0,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic                   in_sub,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic                   out_special,
   output logic                   out_invalid,
   output logic [2:0]             out_type_a,
   output logic [2:0]             out_type_b,
   output logic [TAG_W-1:0]       out_tag,
   output logic [CNT_W-1:0]       special_cnt
);

   localparam int W = 1 + EXP_W + MAN_W;

   localparam logic [2:0] T_ZERO = 3'b000;
   localparam logic [2:0] T_INF  = 3'b001;
   localparam logic [2:0] T_SUB  = 3'b010;
   localparam logic [2:0] T_NORM = 3'b011;
   localparam logic [2:0] T_NAN  = 3'b100;

   localparam logic [EXP_W-1:0] E1        = {EXP_W{1'b1}};
   localparam logic [W-1:0]     CANON_NAN = {1'b0, E1, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   // Operand type from exponent/mantissa fields; FTZ folds subnormals into ZERO.
   function automatic logic [2:0] classify(input logic [W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      logic [2:0]       t;
      e = x[W-2:MAN_W];
      m = x[MAN_W-1:0];
      if (e == '0) begin
         if (m == '0 || FTZ != 0) t = T_ZERO;
         else                     t = T_SUB;
      end else if (e == E1) begin
         if (m == '0) t = T_INF;
         else         t = T_NAN;
      end else begin
         t = T_NORM;
      end
      return t;
   endfunction

   // Flushed subnormals keep only their sign so any passthrough is a clean zero.
   function automatic logic [W-1:0] flush(input logic [W-1:0] x);
      logic [W-1:0] r;
      r = x;
      if (FTZ != 0 && x[W-2:MAN_W] == '0) r = {x[W-1], {(W-1){1'b0}}};
      return r;
   endfunction

   // Quiet NaN: force the mantissa MSB, keep sign and payload.
   function automatic logic [W-1:0] quiet(input logic [W-1:0] x);
      return {x[W-1:MAN_W], 1'b1, x[MAN_W-2:0]};
   endfunction

   // ---------------------------------------------------------------- handshake
   logic s1_valid;
   logic s2_load;
   logic in_fire;

   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;
   assign in_fire  = in_valid && in_ready;

   // ---------------------------------------------------------------- stage 1
   logic [W-1:0]     b_eff;
   logic [W-1:0]     s1_a;
   logic [W-1:0]     s1_b;
   logic [2:0]       s1_ta;
   logic [2:0]       s1_tb;
   logic [TAG_W-1:0] s1_tag;

   assign b_eff = {in_b[W-1] ^ in_sub, in_b[W-2:0]};

   // Stage-1 occupancy: fills on accept, empties when stage 2 takes the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    s1_valid <= 1'b0;
      else if (in_fire)              s1_valid <= 1'b1;
      else if (s1_valid && s2_load)  s1_valid <= 1'b0;
   end

   // Stage-1 payload: operands (B with effective sign), types and tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a   <= '0;
         s1_b   <= '0;
         s1_ta  <= T_ZERO;
         s1_tb  <= T_ZERO;
         s1_tag <= '0;
      end else if (in_fire) begin
         s1_a   <= flush(in_a);
         s1_b   <= flush(b_eff);
         s1_ta  <= classify(in_a);
         s1_tb  <= classify(b_eff);
         s1_tag <= in_tag;
      end
   end

   // ---------------------------------------------------------------- resolve
   logic [W-1:0] res;
   logic         res_special;
   logic         res_invalid;
   logic         a_nan, b_nan, a_zero, b_zero, a_inf, b_inf;

   assign a_nan  = (s1_ta == T_NAN);
   assign b_nan  = (s1_tb == T_NAN);
   assign a_zero = (s1_ta == T_ZERO);
   assign b_zero = (s1_tb == T_ZERO);
   assign a_inf  = (s1_ta == T_INF);
   assign b_inf  = (s1_tb == T_INF);

   // Priority resolution of non-arithmetic cases; first match wins.
   always_comb begin
      res         = '0;
      res_special = 1'b1;
      res_invalid = 1'b0;
      if (a_nan && b_nan) begin
         if (s1_a[MAN_W-2:0] >= s1_b[MAN_W-2:0]) res = quiet(s1_a);
         else                                    res = quiet(s1_b);
      end else if (a_zero && b_zero) begin
         res = {s1_a[W-1] & s1_b[W-1], {(W-1){1'b0}}};
      end else if (a_zero || b_nan) begin
         res = b_nan ? quiet(s1_b) : s1_b;
      end else if (b_zero || a_nan) begin
         res = a_nan ? quiet(s1_a) : s1_a;
      end else if (a_inf) begin
         if (b_inf && (s1_a[W-1] != s1_b[W-1])) begin
            res         = CANON_NAN;
            res_invalid = 1'b1;
         end else begin
            res = s1_a;
         end
      end else if (b_inf) begin
         res = s1_b;
      end else begin
         res_special = 1'b0;
      end
   end

   // ---------------------------------------------------------------- stage 2
   // Output registers; they only move when the consumer side can take data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_special <= 1'b0;
         out_invalid <= 1'b0;
         out_type_a  <= T_ZERO;
         out_type_b  <= T_ZERO;
         out_tag     <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result  <= res;
            out_special <= res_special;
            out_invalid <= res_invalid;
            out_type_a  <= s1_ta;
            out_type_b  <= s1_tb;
            out_tag     <= s1_tag;
         end
      end
   end

   // Saturating count of delivered special results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         special_cnt <= '0;
      else if (out_valid && out_ready && out_special && special_cnt != CNT_MAX)
         special_cnt <= special_cnt + CNT_ONE;
   end

endmodule

`default_nettype wire
